// File: rtl/ct_l2cache_dirty_pkg.sv
// Shared types and helpers for the L2 dirty-array access controller.
// Holds the way/field geometry, FSM encoding and the write-mask expansion.
package ct_l2cache_dirty_pkg;

  localparam int unsigned WAY_NUM = 16;
  localparam int unsigned FIELD_W = 9;
  localparam int unsigned DATA_W  = WAY_NUM * FIELD_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dirty_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] wen;
  } dirty_wr_t;

  // Replicate the field into every selected way; write enables are active-low.
  function automatic dirty_wr_t way_expand(input logic [WAY_NUM-1:0] way,
                                           input logic [FIELD_W-1:0] field);
    dirty_wr_t r;
    r.din = '0;
    r.wen = '1;
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (way[w]) begin
        r.din[w*FIELD_W +: FIELD_W] = field;
        r.wen[w*FIELD_W +: FIELD_W] = '0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ct_l2cache_dirty_ctrl_if.sv
// Pipeline-side and array-side signals of the dirty-array controller.
// slave is the controller's view; master is the pipeline + SRAM wrapper view.
interface ct_l2cache_dirty_ctrl_if
  import ct_l2cache_dirty_pkg::*;
#(
  parameter int unsigned TAG_INDEX_WIDTH = 9
);

  logic                       rd_req;
  logic [TAG_INDEX_WIDTH-1:0] rd_idx;
  logic                       rd_gnt;
  logic                       rd_vld;
  logic [DATA_W-1:0]          rd_data;
  logic                       wr_req;
  logic [TAG_INDEX_WIDTH-1:0] wr_idx;
  logic [WAY_NUM-1:0]         wr_way;
  logic [FIELD_W-1:0]         wr_field;
  logic                       wr_gnt;
  logic                       inv_all_req;
  logic                       init_busy;
  logic                       dirty_cen;
  logic                       dirty_gwen;
  logic [TAG_INDEX_WIDTH-1:0] dirty_idx;
  logic [DATA_W-1:0]          dirty_din;
  logic [DATA_W-1:0]          dirty_wen;
  logic [DATA_W-1:0]          dirty_dout;

  modport slave (
    input  rd_req, rd_idx, wr_req, wr_idx, wr_way, wr_field, inv_all_req, dirty_dout,
    output rd_gnt, rd_vld, rd_data, wr_gnt, init_busy,
           dirty_cen, dirty_gwen, dirty_idx, dirty_din, dirty_wen
  );

  modport master (
    output rd_req, rd_idx, wr_req, wr_idx, wr_way, wr_field, inv_all_req, dirty_dout,
    input  rd_gnt, rd_vld, rd_data, wr_gnt, init_busy,
           dirty_cen, dirty_gwen, dirty_idx, dirty_din, dirty_wen
  );

endinterface

// File: rtl/ct_l2cache_dirty_arb.sv
// Read/write arbiter for the single-port dirty array.
// Reads win unless the write has lost WR_STARVE_MAX times in a row.
module ct_l2cache_dirty_arb #(
  parameter int unsigned WR_STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic rd_req,
  input  logic wr_req,
  output logic rd_gnt_c,
  output logic wr_gnt_c
);

  localparam int unsigned STARVE_W = $clog2(WR_STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                force_wr;

  assign force_wr = (starve_q == STARVE_W'(WR_STARVE_MAX));

  // Grants are combinational in the request cycle; the counter only moves on a lost write.
  always_comb begin
    wr_gnt_c = en & wr_req & (~rd_req | force_wr);
    rd_gnt_c = en & rd_req & ~wr_gnt_c;
    starve_d = starve_q;
    if (!wr_req || wr_gnt_c) begin
      starve_d = '0;
    end else if (rd_gnt_c && !force_wr) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ct_l2cache_dirty_ctrl.sv
// Dirty-array access controller: clear sweep, read/write arbitration and
// registered SRAM control with a two-cycle read return.
module ct_l2cache_dirty_ctrl
  import ct_l2cache_dirty_pkg::*;
#(
  parameter int unsigned TAG_INDEX_WIDTH = 9,
  parameter int unsigned WR_STARVE_MAX   = 4
) (
  input logic                    forever_cpuclk,
  input logic                    cpurst_b,
  ct_l2cache_dirty_ctrl_if.slave bus
);

  dirty_state_t               state_q, state_d;
  logic [TAG_INDEX_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                       cen_q, cen_d;
  logic                       gwen_q, gwen_d;
  logic [TAG_INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]          din_q, din_d;
  logic [DATA_W-1:0]          wen_q, wen_d;
  logic                       rd_pend_q;
  logic                       rd_vld_q;
  logic [DATA_W-1:0]          rd_data_q;
  logic                       run;
  logic                       rd_gnt;
  logic                       wr_gnt;
  dirty_wr_t                  wr_exp;

  assign run    = cpurst_b & (state_q == ST_RUN);
  assign wr_exp = way_expand(bus.wr_way, bus.wr_field);

  ct_l2cache_dirty_arb #(
    .WR_STARVE_MAX (WR_STARVE_MAX)
  ) u_arb (
    .clk      (forever_cpuclk),
    .rst_n    (cpurst_b),
    .en       (run),
    .rd_req   (bus.rd_req),
    .wr_req   (bus.wr_req),
    .rd_gnt_c (rd_gnt),
    .wr_gnt_c (wr_gnt)
  );

  // Next state and next array command; the array sees it one cycle later.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cen_d      = 1'b1;
    gwen_d     = 1'b1;
    idx_d      = idx_q;
    din_d      = din_q;
    wen_d      = '1;
    case (state_q)
      ST_INIT: begin
        cen_d      = 1'b0;
        gwen_d     = 1'b0;
        idx_d      = init_cnt_q;
        din_d      = '0;
        wen_d      = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (wr_gnt) begin
          // An empty way mask is accepted but leaves the array untouched.
          cen_d  = ~|bus.wr_way;
          gwen_d = ~|bus.wr_way;
          idx_d  = bus.wr_idx;
          din_d  = wr_exp.din;
          wen_d  = wr_exp.wen;
        end else if (rd_gnt) begin
          cen_d = 1'b0;
          idx_d = bus.rd_idx;
        end
      end
    endcase
    if (bus.inv_all_req) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      cen_q      <= 1'b1;
      gwen_q     <= 1'b1;
      idx_q      <= '0;
      din_q      <= '0;
      wen_q      <= '1;
      rd_pend_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cen_q      <= cen_d;
      gwen_q     <= gwen_d;
      idx_q      <= idx_d;
      din_q      <= din_d;
      wen_q      <= wen_d;
      rd_pend_q  <= rd_gnt;
      rd_vld_q   <= rd_pend_q;
      if (rd_vld_q) begin
        rd_data_q <= bus.dirty_dout;
      end
    end
  end

  // Read data passes straight from the SRAM Q and is held between valids.
  assign bus.rd_gnt     = rd_gnt;
  assign bus.wr_gnt     = wr_gnt;
  assign bus.rd_vld     = rd_vld_q;
  assign bus.rd_data    = rd_vld_q ? bus.dirty_dout : rd_data_q;
  assign bus.init_busy  = ~cpurst_b | (state_q == ST_INIT);
  assign bus.dirty_cen  = cen_q;
  assign bus.dirty_gwen = gwen_q;
  assign bus.dirty_idx  = idx_q;
  assign bus.dirty_din  = din_q;
  assign bus.dirty_wen  = wen_q;

endmodule

// File: tb/tb_ct_l2cache_dirty_ctrl.sv
// Randomized scoreboard bench for ct_l2cache_dirty_ctrl with an SRAM model
// and a behavioural model of arbitration, clear sweeps and array contents.
module tb_ct_l2cache_dirty_ctrl;
  import ct_l2cache_dirty_pkg::*;

  localparam int unsigned IW    = 9;
  localparam int unsigned DEPTH = 1 << IW;
  localparam int          SMAX  = 4;

  typedef struct {
    bit                wr;
    int unsigned       idx;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] wen;
  } acc_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   rst_next;

  ct_l2cache_dirty_ctrl_if #(.TAG_INDEX_WIDTH(IW)) bus ();

  ct_l2cache_dirty_ctrl #(
    .TAG_INDEX_WIDTH (IW),
    .WR_STARVE_MAX   (4)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // SRAM wrapper model: registered Q, bit-level active-low write enables.
  logic [DATA_W-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (bus.dirty_cen == 1'b0) begin
      if (bus.dirty_gwen == 1'b0)
        sram[bus.dirty_idx] <= (sram[bus.dirty_idx] & bus.dirty_wen) | (bus.dirty_din & ~bus.dirty_wen);
      else
        bus.dirty_dout <= sram[bus.dirty_idx];
    end
  end

  acc_t              acc_q[$];
  logic [DATA_W-1:0] rd_q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] last_rd = '0;
  bit                in_init;
  int                init_next;
  int                starve;
  int                checks = 0;
  int                errors = 0;
  int                wr_seen;

  function automatic void chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  // One clock: drive at negedge, then predict this cycle's outcome from the rules.
  task automatic cyc(input bit rd, input int unsigned ri, input bit wr, input int unsigned wi,
                     input logic [WAY_NUM-1:0] way, input logic [FIELD_W-1:0] fld, input bit inv);
    bit                eg_rd, eg_wr;
    acc_t              a;
    logic [DATA_W-1:0] d, m;
    @(negedge clk);
    rst_n           = rst_next;
    bus.rd_req      = rd;
    bus.rd_idx      = IW'(ri);
    bus.wr_req      = wr;
    bus.wr_idx      = IW'(wi);
    bus.wr_way      = way;
    bus.wr_field    = fld;
    bus.inv_all_req = inv;
    #1;
    eg_rd = 1'b0;
    eg_wr = 1'b0;
    if (!rst_next) begin
      chk("init_busy_rst", DATA_W'(bus.init_busy), DATA_W'(1));
      in_init   = 1'b1;
      init_next = 0;
      starve    = 0;
    end else begin
      chk("init_busy", DATA_W'(bus.init_busy), DATA_W'(in_init));
      if (in_init) begin
        a.wr = 1'b1; a.idx = init_next; a.din = '0; a.wen = '0;
        acc_q.push_back(a);
        ref_mem[init_next] = '0;
        if (inv) init_next = 0;
        else if (init_next == DEPTH - 1) in_init = 1'b0;
        else init_next++;
        if (!wr) starve = 0;
      end else begin
        if (wr && (!rd || starve == SMAX)) eg_wr = 1'b1;
        else if (rd) eg_rd = 1'b1;
        if (eg_wr && way != '0) begin
          d = '0;
          m = '1;
          for (int w = 0; w < WAY_NUM; w++) begin
            if (way[w]) begin
              d[w*FIELD_W +: FIELD_W] = fld;
              m[w*FIELD_W +: FIELD_W] = '0;
              ref_mem[wi][w*FIELD_W +: FIELD_W] = fld;
            end
          end
          a.wr = 1'b1; a.idx = wi; a.din = d; a.wen = m;
          acc_q.push_back(a);
        end
        if (eg_rd) begin
          a.wr = 1'b0; a.idx = ri; a.din = '0; a.wen = '1;
          acc_q.push_back(a);
          rd_q.push_back(ref_mem[ri]);
        end
        if (!wr || eg_wr) starve = 0;
        else if (eg_rd && starve < SMAX) starve++;
        if (inv) begin
          in_init   = 1'b1;
          init_next = 0;
        end
      end
    end
    chk("rd_gnt", DATA_W'(bus.rd_gnt), DATA_W'(eg_rd));
    chk("wr_gnt", DATA_W'(bus.wr_gnt), DATA_W'(eg_wr));
    if (bus.wr_gnt) wr_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, '0, '0, 1'b0);
  endtask

  task automatic rand_cyc(input bit allow_inv);
    logic [WAY_NUM-1:0] way;
    way = ($urandom_range(7) == 0) ? '0 : WAY_NUM'($urandom);
    cyc(1'($urandom), $urandom_range(15), 1'($urandom), $urandom_range(15), way,
        FIELD_W'($urandom), allow_inv && ($urandom_range(199) == 0));
  endtask

  task automatic wait_sweep(input bit random_reqs);
    int n;
    n = 0;
    while (in_init && n < 1200) begin
      if (random_reqs) rand_cyc(1'b0);
      else idle(1);
      n++;
    end
    if (in_init) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout actual=busy required=done");
    end
  endtask

  // Monitor: every array access and every returned read is popped and compared.
  initial begin
    acc_t a;
    logic [DATA_W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.dirty_cen === 1'b0) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL array_access actual=idx_%0h required=no_access", bus.dirty_idx);
        end else begin
          a = acc_q.pop_front();
          chk("acc_idx", DATA_W'(bus.dirty_idx), DATA_W'(a.idx));
          chk("acc_gwen", DATA_W'(bus.dirty_gwen), DATA_W'(!a.wr));
          chk("acc_wen", bus.dirty_wen, a.wen);
          if (a.wr) chk("acc_din", bus.dirty_din & ~bus.dirty_wen, a.din & ~a.wen);
        end
      end
      if (bus.rd_vld === 1'b1) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_vld actual=1 required=0");
        end else begin
          e = rd_q.pop_front();
          chk("rd_data", bus.rd_data, e);
          last_rd = e;
        end
      end else begin
        chk("rd_data_hold", bus.rd_data, last_rd);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = DATA_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      ref_mem[i] = '1;
    end
    rst_next  = 1'b0;
    rst_n     = 1'b0;
    in_init   = 1'b1;
    init_next = 0;
    starve    = 0;
    idle(3);
    chk("rst_cen", DATA_W'(bus.dirty_cen), DATA_W'(1));
    chk("rst_gwen", DATA_W'(bus.dirty_gwen), DATA_W'(1));
    chk("rst_wen", bus.dirty_wen, '1);
    chk("rst_idx", DATA_W'(bus.dirty_idx), '0);
    chk("rst_din", bus.dirty_din, '0);
    chk("rst_rd_vld", DATA_W'(bus.rd_vld), '0);

    rst_next = 1'b1;
    wait_sweep(1'b0);

    cyc(1'b0, 0, 1'b1, 5, 16'h0003, 9'h001, 1'b0);
    cyc(1'b1, 5, 1'b0, 0, '0, '0, 1'b0);
    idle(1);
    chk("wen_way01", bus.dirty_wen, '1);
    idle(2);
    cyc(1'b0, 0, 1'b1, 7, 16'h8000, 9'h1FF, 1'b0);
    cyc(1'b1, 7, 1'b0, 0, '0, '0, 1'b0);
    idle(3);
    cyc(1'b0, 0, 1'b1, 9, 16'h0000, 9'h1FF, 1'b0);
    idle(2);

    wr_seen = 0;
    for (int i = 0; i < 15; i++)
      cyc(1'b1, $urandom_range(15), 1'b1, $urandom_range(15), WAY_NUM'($urandom) | 16'h0001,
          FIELD_W'($urandom), 1'b0);
    chk("starve_wr_count", DATA_W'(wr_seen), DATA_W'(3));
    idle(3);

    cyc(1'b1, 5, 1'b0, 0, '0, '0, 1'b0);
    cyc(1'b1, 7, 1'b1, 3, 16'h00F0, 9'h0AA, 1'b1);
    for (int i = 0; i < 100; i++) rand_cyc(1'b0);
    cyc(1'b1, 2, 1'b1, 2, 16'h0001, 9'h011, 1'b1);
    wait_sweep(1'b1);

    for (int i = 0; i < 400; i++) rand_cyc(1'b0);
    wait_sweep(1'b0);
    for (int i = 0; i < 300; i++) rand_cyc(1'b0);
    idle(6);
    chk("acc_q_drained", DATA_W'(acc_q.size()), '0);
    chk("rd_q_drained", DATA_W'(rd_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_l2cache_dirty_ctrl.md
Name: ct_l2cache_dirty_ctrl

Overview:
Access controller for the 16-way L2 dirty array (144-bit word per index: 16 ways x 9-bit field). It does three things:
- Arbitrates pipeline read and pipeline write requests onto the single-port array.
- Runs the array clear sequence after reset and on invalidate-all.
- Returns read data with fixed latency.
It sits between the L2 tag/dirty pipeline and the dirty-array SRAM wrapper.

Parameters:
TAG_INDEX_WIDTH, `L2C_TAG_INDEX_WIDTH (9 for 1M), index width; array depth = 2**TAG_INDEX_WIDTH
WAY_NUM, 16, ways per index
FIELD_W, 9, bits per way field (WAY_NUM*FIELD_W = 144)
WR_STARVE_MAX, 4, consecutive write losses before a write is forced through

Ports:
forever_cpuclk  in  1  clock
cpurst_b  in  1  reset, synchronous, active-low
rd_req  in  1  pipeline read request
rd_idx  in  TAG_INDEX_WIDTH  read index
rd_gnt  out  1  read accepted this cycle
rd_vld  out  1  read data valid
rd_data  out  144  read data
wr_req  in  1  pipeline write request
wr_idx  in  TAG_INDEX_WIDTH  write index
wr_way  in  16  way mask (one or more ways)
wr_field  in  9  field value written to every selected way
wr_gnt  out  1  write accepted this cycle
inv_all_req  in  1  pulse: clear whole array
init_busy  out  1  clear sequence in progress
dirty_cen  out  1  array chip enable, active-low
dirty_gwen  out  1  array global write enable, active-low
dirty_idx  out  TAG_INDEX_WIDTH  array address
dirty_din  out  144  array write data
dirty_wen  out  144  array bit write enable, active-low
dirty_dout  in  144  array read data

Behaviour:
- FSM states: INIT (clear sweep), IDLE/RUN (arbitrate). Reset enters INIT with init_cnt = 0.
- Reset values:
  - rd_gnt = wr_gnt = rd_vld = 0; rd_data = 0.
  - dirty_cen = dirty_gwen = 1; dirty_wen = all-1; dirty_idx = 0; dirty_din = 0.
  - init_busy = 1 during the reset cycle and after; starve_cnt = 0.
- Array control outputs are registered: the request is sampled in cycle N and drives the array in cycle N+1.
- INIT, each cycle:
  - Write index init_cnt with din = 0, wen = all-0, gwen = 0, cen = 0.
  - init_cnt increments; after writing index 2**TAG_INDEX_WIDTH-1, go to RUN.
  - Sweep takes exactly 2**TAG_INDEX_WIDTH array writes.
  - init_busy = 1 throughout; no grants.
- inv_all_req:
  - In RUN: goes to INIT next cycle with init_cnt = 0. A request granted in the same cycle still completes; later ones wait.
  - In INIT: restarts the sweep at 0.
  - Pending rd_vld is delivered regardless.
- RUN arbitration (combinational grant in the request cycle):
  - Read beats write, except when starve_cnt == WR_STARVE_MAX: then write wins and starve_cnt clears.
  - starve_cnt increments when wr_req loses and saturates; it clears on wr_gnt or when wr_req is low.
  - At most one grant per cycle.
- Write:
  - din = replication of wr_field into each selected way's field; wen is 0 only on selected ways' 9 bits.
  - gwen = 0, cen = 0.
  - wr_way == 0 is granted and produces no array access (cen = 1).
- Read:
  - cen = 0, gwen = 1, wen = all-1.
  - Array Q is valid the cycle after the access, so rd_vld/rd_data appear 2 cycles after rd_gnt.
  - rd_data is driven from dirty_dout combinationally with a registered valid.
  - rd_data holds its last value when rd_vld = 0.
- Read after write to the same index in back-to-back grants returns the new value; the single port orders them, so no bypass is needed.
- Idle cycle: cen = 1.

Decomposition:
- Package ct_l2cache_dirty_pkg: WAY_NUM, FIELD_W, FSM state encodings (INIT, RUN), and the field-replicate/way-mask-expand function producing din/wen from wr_way and wr_field.
- Natural sub-module: ct_l2cache_dirty_arb, holding the read/write priority, starvation counter and grant logic.
- The INIT sweep and array output registers stay in the top module.

Test Plan:
- Reset with TAG_INDEX_WIDTH=9 -> init_busy = 1 for exactly 512 array writes (idx 0..511, din = 0, wen = 0); no grants; then init_busy = 0.
- wr_req idx 5, wr_way 16'h0003, wr_field 9'h001; then rd_req idx 5 -> dirty_wen bits [17:0] low, rest high; rd_vld 2 cycles after rd_gnt; rd_data[17:0] = 18'h00201, rest 0.
- rd_req and wr_req held high continuously -> 4 read grants, then 1 write grant, repeating; starve_cnt never exceeds 4.
- inv_all_req pulsed mid-RUN while a read is outstanding -> that read's rd_vld still arrives; sweep restarts at idx 0; no grants until the sweep completes.
- wr_req with wr_way 0 -> wr_gnt = 1; dirty_cen stays 1 the next cycle.
- Write idx 7 way 15 field 9'h1FF, read idx 7 in the next cycle -> rd_data[143:135] = 9'h1FF.
